// File: rtl/anim_sequencer.sv
// anim_sequencer: multi-channel animation sequencer between sprite ROMs and the SPI LCD driver.
// Picks one of NUM_ANIM pixel sources, drives the active frame index to the ROMs and advances
// frames on LCD frame boundaries. Channel switches only take effect at a frame boundary, so a
// frame is never torn. Channels flagged in ONESHOT_MASK play once, then fall back to channel 0.
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   go                button level; a rising edge requests channel (anim_id+1) mod NUM_ANIM
//   sel_valid/sel_id  one-cycle request to jump to sel_id (out-of-range ids ignored)
//   frame_done        one-cycle pulse from the LCD driver at the end of each frame
//   ram_addr_x/y      pixel coordinate from the LCD driver
//   src_data          flat ROM outputs, channel i at [i*PIX_W +: PIX_W]
//   pause             (ANIM_PAUSE_EN only) freezes frame advance while high
//   anim_id           active channel
//   frame_idx         active frame to the ROMs
//   ram_data          pixel to the LCD driver, one cycle after its address
//   pending           a switch request is waiting for frame_done
//
// Optional feature: define ANIM_PAUSE_EN to add the pause input.
`timescale 1ns/1ps
module anim_sequencer #(
   parameter int unsigned          NUM_ANIM     = 4,
   parameter int unsigned          FRAMES       = 8,
   parameter int unsigned          HOLD_FRAMES  = 6,
   parameter int unsigned          PIX_W        = 16,
   parameter int unsigned          LCD_W        = 132,
   parameter int unsigned          LCD_H        = 162,
   parameter logic [PIX_W-1:0]     BG_COLOR     = 16'h0000,
   parameter logic [NUM_ANIM-1:0]  ONESHOT_MASK = 4'b1110,
   localparam int unsigned         AW           = $clog2(NUM_ANIM),
   localparam int unsigned         FW           = $clog2(FRAMES)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      go,
   input  logic                      sel_valid,
   input  logic [AW-1:0]             sel_id,
   input  logic                      frame_done,
   input  logic [7:0]                ram_addr_x,
   input  logic [7:0]                ram_addr_y,
   input  logic [NUM_ANIM*PIX_W-1:0] src_data,
`ifdef ANIM_PAUSE_EN
   input  logic                      pause,
`endif
   output logic [AW-1:0]             anim_id,
   output logic [FW-1:0]             frame_idx,
   output logic [PIX_W-1:0]          ram_data,
   output logic                      pending
);

   localparam int unsigned HW = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;

   typedef enum logic [0:0] {StLoop, StOneshot} state_e;

   state_e            state_q, state_d;
   logic [AW-1:0]     anim_q, anim_d;
   logic [AW-1:0]     req_q, req_d;
   logic [FW-1:0]     frame_q, frame_d;
   logic [HW-1:0]     hold_q, hold_d;
   logic              pending_q, pending_d;
   logic              go_q;
   logic [PIX_W-1:0]  ram_data_q, ram_data_d;

   logic              go_rise;
   logic              sel_ok;
   logic              advance_ok;
   logic [AW-1:0]     next_id;
   logic [PIX_W-1:0]  pix_sel;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StLoop;
         anim_q     <= '0;
         req_q      <= '0;
         frame_q    <= '0;
         hold_q     <= '0;
         pending_q  <= 1'b0;
         go_q       <= 1'b0;
         ram_data_q <= BG_COLOR;
      end else begin
         state_q    <= state_d;
         anim_q     <= anim_d;
         req_q      <= req_d;
         frame_q    <= frame_d;
         hold_q     <= hold_d;
         pending_q  <= pending_d;
         go_q       <= go;
         ram_data_q <= ram_data_d;
      end
   end

   always_comb begin
      go_rise = go & ~go_q;
      sel_ok  = sel_valid && (32'(sel_id) < NUM_ANIM);
      next_id = (anim_q == AW'(NUM_ANIM - 1)) ? '0 : anim_q + AW'(1);
`ifdef ANIM_PAUSE_EN
      advance_ok = ~pause;
`else
      advance_ok = 1'b1;
`endif
   end

   always_comb begin
      state_d   = state_q;
      anim_d    = anim_q;
      req_d     = req_q;
      frame_d   = frame_q;
      hold_d    = hold_q;
      pending_d = pending_q;

      if (frame_done) begin
         if (pending_q) begin
            anim_d    = req_q;
            frame_d   = '0;
            hold_d    = '0;
            pending_d = 1'b0;
            state_d   = ONESHOT_MASK[req_q] ? StOneshot : StLoop;
         end else if (advance_ok) begin
            if (hold_q == HW'(HOLD_FRAMES - 1)) begin
               hold_d = '0;
               unique case (state_q)
                  StLoop: begin
                     frame_d = (frame_q == FW'(FRAMES - 1)) ? '0 : frame_q + FW'(1);
                  end
                  StOneshot: begin
                     if (frame_q == FW'(FRAMES - 1)) begin
                        anim_d  = '0;
                        frame_d = '0;
                        state_d = StLoop;
                     end else begin
                        frame_d = frame_q + FW'(1);
                     end
                  end
                  default: state_d = StLoop;
               endcase
            end else begin
               hold_d = hold_q + HW'(1);
            end
         end
      end

      // A request in the frame_done cycle is latched after the apply above, so it waits for the
      // next boundary instead of being lost.
      if (sel_ok) begin
         req_d     = sel_id;
         pending_d = 1'b1;
      end else if (go_rise) begin
         req_d     = next_id;
         pending_d = 1'b1;
      end
   end

   always_comb begin
      pix_sel = BG_COLOR;
      for (int i = 0; i < NUM_ANIM; i++) begin
         if (anim_q == AW'(i)) pix_sel = src_data[i*PIX_W +: PIX_W];
      end
      if ((32'(ram_addr_x) >= LCD_W) || (32'(ram_addr_y) >= LCD_H)) begin
         ram_data_d = BG_COLOR;
      end else begin
         ram_data_d = pix_sel;
      end
   end

   assign anim_id   = anim_q;
   assign frame_idx = frame_q;
   assign ram_data  = ram_data_q;
   assign pending   = pending_q;

endmodule
